pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline control unit for the five-stage MIPS core. It merges stall requests from IF, ID (load-use hazards the forwarding paths cannot cover) and EX into the per-stage stall vector. It sequences multi-cycle EX operations (madd/msub/div class) with a countdown FSM. It issues a one-cycle pipeline flush with the exception vector, and keeps a saturating stall-cycle statistics counter.

Parameters:
LEN_W, 6, width of the multi-cycle length field and the internal countdown
STAT_W, 32, width of the stall-cycle statistics counter
EXC_VECTOR, 32'h00000020, PC value driven on new_pc_o during a flush

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stallreq_if_i  input  1  IF stage requests stall
stallreq_id_i  input  1  ID stage requests stall (load-use)
stallreq_ex_i  input  1  EX stage requests stall (external reason)
mc_start_i  input  1  EX starts a multi-cycle op this cycle
mc_len_i  input  LEN_W  total EX occupancy in cycles for the op
flush_req_i  input  1  exception/flush request from MEM
stat_clr_i  input  1  clear the statistics counter
stall_o  output  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold stage
flush_o  output  1  flush all pipeline registers this cycle
new_pc_o  output  32  redirect PC, valid when flush_o=1
mc_busy_o  output  1  FSM in BUSY
mc_done_o  output  1  registered pulse: multi-cycle result valid in EX this cycle
stall_cycles_o  output  STAT_W  count of cycles with stall_o[0]=1

Behaviour:
- Reset (rst=1 at edge): state<=IDLE, cnt<=0, mc_done_o<=0, stall_cycles_o<=0.
- While rst=1, the combinational outputs are held as follows: stall_o=0, flush_o=0, new_pc_o=0.
- FSM states are IDLE, BUSY and DONE. A start is accepted in IDLE or DONE only; mc_start_i in BUSY is ignored.
- L = max(mc_len_i, 1).
- Start accepted with L>=2: go to BUSY, cnt<=L-2.
- Start accepted with L=1: go to DONE.
- BUSY: if cnt==0, go to DONE; otherwise cnt<=cnt-1.
- DONE: mc_done_o=1 for exactly one cycle. Next state is IDLE, unless a new start is accepted (back-to-back starts are allowed).
- mc_stall = (start accepted this cycle) OR (state==BUSY). Result: exactly L stall cycles, and mc_done_o in cycle L after the start cycle.
- Stall vector (combinational), first match wins:
  - flush_req_i: stall_o=000000.
  - mc_stall or stallreq_ex_i: stall_o=001111.
  - stallreq_id_i: stall_o=000111.
  - stallreq_if_i: stall_o=000011.
  - Otherwise: stall_o=000000.
- Flush:
  - flush_o = flush_req_i, combinational. new_pc_o=EXC_VECTOR when flush_o=1, else 0.
  - At the edge: state<=IDLE, cnt<=0, mc_done_o<=0.
  - Flush overrides a same-cycle start (start not accepted) and aborts BUSY mid-operation with no mc_done_o.
- mc_busy_o = (state==BUSY).
- Statistics counter:
  - stat_clr_i=1: counter<=0 (clear wins over increment).
  - Else, if stall_o[0]=1 and counter != all-ones: counter+1.
  - Saturates at 2^STAT_W-1 and does not wrap.
- No combinational path from mc_done_o to stall_o; mc_done_o is a flop output.

Test Plan:
- Reset: hold rst 2 cycles with all requests active -> stall_o=0, flush_o=0, mc_done_o=0, stall_cycles_o=0; release -> IDLE.
- mc_start_i=1, mc_len_i=3 for one cycle -> stall_o=001111 for cycles 0,1,2; mc_busy_o=1 in cycles 1,2; mc_done_o=1 in cycle 3 only; stall_cycles_o=3.
- mc_len_i=0 and mc_len_i=1 -> each gives 1 stall cycle, then mc_done_o in the next cycle. Restart during DONE with len 2 -> stalls continue seamlessly, second done 2 cycles later.
- Priority: stallreq_id_i=1 and stallreq_if_i=1 -> 000111. Add stallreq_ex_i -> 001111. Add flush_req_i -> 000000, flush_o=1, new_pc_o=32'h00000020.
- Flush in BUSY (len 10, flush in cycle 4) -> state IDLE next cycle, mc_done_o never pulses. mc_start_i with flush_req_i in the same cycle -> no BUSY.
- Statistics: force counter near saturation (STAT_W=4 build) with stall held for 20 cycles -> stops at 15. Assert stat_clr_i while stalled -> reads 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences multi-cycle EX ops, issues flushes, counts stall cycles.
// Latency: stall_o/flush_o/new_pc_o are combinational; mc_done_o is registered and fires L cycles after an accepted start.
// Backpressure: stall_o holds the stages upstream of the requester; mc_start_i is ignored while BUSY or during a flush.
//
// Ports:
//   clk, rst          : core clock, synchronous active-high reset
//   stallreq_*_i      : stall requests from IF, ID (load-use) and EX
//   mc_start_i/len_i  : start a multi-cycle EX op occupying mc_len_i cycles (0 treated as 1)
//   flush_req_i       : exception flush from MEM
//   stat_clr_i        : clear the stall-cycle statistics counter
//   stall_o[5:0]      : {wb, mem, ex, id, if, pc} hold bits
//   flush_o, new_pc_o : flush strobe and redirect PC
//   mc_busy_o         : multi-cycle op in progress
//   mc_done_o         : one-cycle pulse, multi-cycle result valid in EX
//   stall_cycles_o    : saturating count of cycles with the PC held
module pipe_ctrl #(
  parameter int          LEN_W      = 6,
  parameter int          STAT_W     = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if_i,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              mc_start_i,
  input  logic [LEN_W-1:0]  mc_len_i,
  input  logic              flush_req_i,
  input  logic              stat_clr_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [STAT_W-1:0] stall_cycles_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_TWO = LEN_ONE + LEN_ONE;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_eff;
  logic             start_acc;
  logic             mc_stall;

  // A zero length still occupies EX for one cycle.
  assign len_eff   = (mc_len_i == '0) ? LEN_ONE : mc_len_i;
  // Flush kills a same-cycle start; BUSY ignores new starts.
  assign start_acc = mc_start_i && !flush_req_i && (state != BUSY);
  assign mc_stall  = start_acc || (state == BUSY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mc_done_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // DONE lasts exactly one cycle, so the pulse is simply "entering DONE".
      mc_done_o <= (state_nxt == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush_req_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (start_acc) begin
      // The start cycle itself is the first stall cycle, BUSY covers the
      // remaining L-1, hence the L-2 preload.
      if (len_eff > LEN_ONE) begin
        state_nxt = BUSY;
        cnt_nxt   = len_eff - LEN_TWO;
      end else begin
        state_nxt = DONE;
      end
    end else begin
      case (state)
        BUSY: begin
          if (cnt == '0) state_nxt = DONE;
          else           cnt_nxt   = cnt - LEN_ONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall_o   = 6'b000000;
    flush_o   = 1'b0;
    new_pc_o  = 32'h0;
    mc_busy_o = (state == BUSY);
    if (!rst) begin
      flush_o  = flush_req_i;
      new_pc_o = flush_req_i ? EXC_VECTOR : 32'h0;
      if (flush_req_i)                      stall_o = 6'b000000;
      else if (mc_stall || stallreq_ex_i)   stall_o = 6'b001111;
      else if (stallreq_id_i)               stall_o = 6'b000111;
      else if (stallreq_if_i)               stall_o = 6'b000011;
      else                                  stall_o = 6'b000000;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (rst || stat_clr_i) begin
      stall_cycles_o <= '0;
    end else if (stall_o[0] && (stall_cycles_o != {STAT_W{1'b1}})) begin
      stall_cycles_o <= stall_cycles_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed stimulus with a done-cycle scoreboard.
// Latency: inputs change 1 time unit after a rising edge, combinational outputs are checked 1 unit later.
// Backpressure: none; the bench drives every cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i;
  logic        mc_start_i;
  logic [5:0]  mc_len_i;
  logic        flush_req_i;
  logic        stat_clr_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_done_o;
  logic [3:0]  stall_cycles_o;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_q[$];

  pipe_ctrl #(.LEN_W(6), .STAT_W(4), .EXC_VECTOR(32'h00000020)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .mc_start_i     (mc_start_i),
    .mc_len_i       (mc_len_i),
    .flush_req_i    (flush_req_i),
    .stat_clr_i     (stat_clr_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .mc_busy_o      (mc_busy_o),
    .mc_done_o      (mc_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if_i = 1'b0;
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b0;
    mc_start_i    = 1'b0;
    mc_len_i      = 6'd0;
    flush_req_i   = 1'b0;
    stat_clr_i    = 1'b0;
  endtask

  // Every done pulse must match the oldest expected completion cycle.
  always @(negedge clk) begin
    if (!rst && mc_done_o) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'(mc_done_o), 32'd0);
      else                    chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every request active.
    rst = 1'b1;
    stallreq_if_i = 1'b1; stallreq_id_i = 1'b1; stallreq_ex_i = 1'b1;
    mc_start_i = 1'b1; mc_len_i = 6'd3; flush_req_i = 1'b1; stat_clr_i = 1'b0;
    next_cyc();
    next_cyc();
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    chk("rst_done", 32'(mc_done_o), 32'h0);
    chk("rst_stat", 32'(stall_cycles_o), 32'h0);
    chk("rst_busy", 32'(mc_busy_o), 32'h0);
    rst = 1'b0;
    clear_inputs();
    next_cyc();
    chk("idle_stall", 32'(stall_o), 32'h0);
    chk("idle_busy", 32'(mc_busy_o), 32'h0);

    // len 3: stalls in cycles 0..2, busy in 1..2, done in 3.
    stat_clr_i = 1'b1;
    next_cyc();
    stat_clr_i = 1'b0;
    mc_start_i = 1'b1; mc_len_i = 6'd3;
    done_q.push_back(cyc + 3);
    settle();
    chk("l3_c0_stall", 32'(stall_o), 32'h0F);
    chk("l3_c0_busy", 32'(mc_busy_o), 32'h0);
    next_cyc();
    mc_start_i = 1'b0;
    settle();
    chk("l3_c1_stall", 32'(stall_o), 32'h0F);
    chk("l3_c1_busy", 32'(mc_busy_o), 32'h1);
    next_cyc();
    chk("l3_c2_stall", 32'(stall_o), 32'h0F);
    chk("l3_c2_busy", 32'(mc_busy_o), 32'h1);
    next_cyc();
    chk("l3_c3_stall", 32'(stall_o), 32'h0);
    chk("l3_c3_busy", 32'(mc_busy_o), 32'h0);
    chk("l3_c3_done", 32'(mc_done_o), 32'h1);
    chk("l3_stat", 32'(stall_cycles_o), 32'd3);
    next_cyc();
    chk("l3_c4_done", 32'(mc_done_o), 32'h0);

    // len 0 and len 1 each behave as a single stall cycle.
    for (int i = 0; i < 2; i++) begin
      mc_start_i = 1'b1; mc_len_i = 6'(i);
      done_q.push_back(cyc + 1);
      settle();
      chk("short_stall", 32'(stall_o), 32'h0F);
      next_cyc();
      mc_start_i = 1'b0;
      settle();
      chk("short_after_stall", 32'(stall_o), 32'h0);
      chk("short_done", 32'(mc_done_o), 32'h1);
      next_cyc();
    end

    // Restart while in DONE: stalls continue without a gap.
    mc_start_i = 1'b1; mc_len_i = 6'd1;
    done_q.push_back(cyc + 1);
    next_cyc();
    mc_len_i = 6'd2;
    done_q.push_back(cyc + 2);
    settle();
    chk("b2b_done1", 32'(mc_done_o), 32'h1);
    chk("b2b_c0_stall", 32'(stall_o), 32'h0F);
    next_cyc();
    mc_start_i = 1'b0;
    settle();
    chk("b2b_c1_stall", 32'(stall_o), 32'h0F);
    chk("b2b_c1_busy", 32'(mc_busy_o), 32'h1);
    next_cyc();
    chk("b2b_c2_stall", 32'(stall_o), 32'h0);
    chk("b2b_done2", 32'(mc_done_o), 32'h1);
    next_cyc();

    // Stall priority.
    stallreq_if_i = 1'b1;
    settle();
    chk("pri_if", 32'(stall_o), 32'h03);
    stallreq_id_i = 1'b1;
    settle();
    chk("pri_id_if", 32'(stall_o), 32'h07);
    stallreq_ex_i = 1'b1;
    settle();
    chk("pri_ex", 32'(stall_o), 32'h0F);
    chk("pri_noflush", 32'(flush_o), 32'h0);
    flush_req_i = 1'b1;
    settle();
    chk("pri_flush_stall", 32'(stall_o), 32'h0);
    chk("pri_flush", 32'(flush_o), 32'h1);
    chk("pri_newpc", new_pc_o, 32'h00000020);
    clear_inputs();
    next_cyc();

    // Flush aborts a len-10 op in cycle 4: no done pulse afterwards.
    mc_start_i = 1'b1; mc_len_i = 6'd10;
    next_cyc();
    mc_start_i = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    flush_req_i = 1'b1;
    settle();
    chk("abort_busy_pre", 32'(mc_busy_o), 32'h1);
    chk("abort_stall", 32'(stall_o), 32'h0);
    next_cyc();
    flush_req_i = 1'b0;
    settle();
    chk("abort_busy_post", 32'(mc_busy_o), 32'h0);
    chk("abort_stall_post", 32'(stall_o), 32'h0);
    for (int i = 0; i < 10; i++) next_cyc();
    chk("abort_no_done", 32'(mc_done_o), 32'h0);

    // Start and flush together: start dropped.
    mc_start_i = 1'b1; mc_len_i = 6'd4; flush_req_i = 1'b1;
    settle();
    chk("sf_stall", 32'(stall_o), 32'h0);
    next_cyc();
    clear_inputs();
    settle();
    chk("sf_busy", 32'(mc_busy_o), 32'h0);
    chk("sf_done", 32'(mc_done_o), 32'h0);

    // Statistics saturation and clear.
    stat_clr_i = 1'b1;
    next_cyc();
    stat_clr_i = 1'b0;
    stallreq_if_i = 1'b1;
    for (int i = 0; i < 20; i++) next_cyc();
    chk("stat_sat", 32'(stall_cycles_o), 32'd15);
    stat_clr_i = 1'b1;
    next_cyc();
    chk("stat_clr", 32'(stall_cycles_o), 32'd0);
    stat_clr_i = 1'b0;
    next_cyc();
    chk("stat_restart", 32'(stall_cycles_o), 32'd1);
    clear_inputs();
    next_cyc();
    next_cyc();

    chk("sb_empty", done_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
